cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Line-refill controller sitting directly downstream of the 4-way set-associative cache, between the cache and main memory. On a cache miss it fetches the missing 128-bit line as four 32-bit memory beats and assembles them. It then presents the full line to the cache for one cycle as a write (line, line address, write strobe). A build option writes a dirty victim line back to memory before the refill.

## Interface
- `LINE_W`, 128, cache line width in bits; fixed at 4 × `WORD_W`
- `WORD_W`, 32, memory beat width in bits
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_v_i`  in  1  miss request valid
- `req_addr_i`  in  32  miss address; bits [3:0] ignored
- `req_ready_o`  out  1  controller idle, request accepted this cycle if `req_v_i`
- `victim_dirty_i`  in  1  selected victim line is dirty; sampled at accept
- `victim_addr_i`  in  32  victim line address; bits [3:0] ignored
- `victim_line_i`  in  128  victim line data
- `mem_ren_o`  out  1  memory read beat request
- `mem_wen_o`  out  1  memory write beat request
- `mem_addr_o`  out  32  beat address = line base + 4×beat
- `mem_wdata_o`  out  32  write beat data
- `mem_ack_i`  in  1  memory completed current beat this cycle
- `mem_rdata_i`  in  32  read beat data, valid with `mem_ack_i`
- `fill_wen_o`  out  1  one-cycle write strobe into cache (`wen_i`)
- `fill_addr_o`  out  32  refilled line address, bits [3:0] = 0
- `fill_line_o`  out  128  assembled line; word k at bits [32k+31:32k]
- `busy_o`  out  1  not idle

## Operation
- FSM states: IDLE, WB, RD, FILL. 2-bit beat counter; line base register; 128-bit assembly register; 128-bit victim register.
- IDLE: `req_ready_o`=1. Accept on `req_v_i`: latch `{req_addr_i[31:4],4'b0}` as base, clear beat counter. Go to WB if the writeback option is built and `victim_dirty_i`=1. Otherwise go to RD.
- WB: `mem_wen_o`=1, `mem_addr_o` = victim base + 4×beat, `mem_wdata_o` = victim word[beat]. Each `mem_ack_i` advances the beat. Ack on beat 3 → RD with beat counter cleared.
- RD: `mem_ren_o`=1, `mem_addr_o` = base + 4×beat. On `mem_ack_i`, `mem_rdata_i` → assembly word[beat] and beat advances. Ack on beat 3 → FILL.
- FILL: `fill_wen_o`=1 for exactly one cycle, with `fill_addr_o` = base and `fill_line_o` = assembled line. Next state is IDLE.
- `mem_ren_o` and `mem_wen_o` are never both 1. Requests stay asserted, with stable address and data, until acked.
- Boundary rules:
  - `req_v_i` outside IDLE is ignored, not queued; the requester holds it.
  - `mem_ack_i` in IDLE or FILL is ignored.
  - Beat addresses never leave the line; the base is 16-byte aligned.
  - Beat counter wraps 3→0 only on the final ack.
- Reset, including mid-burst: next state IDLE. Partial line and victim discarded, outstanding memory beat abandoned.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from `mem_*_i` to outputs.
- Reset values: `req_ready_o`=1; `busy_o`, `mem_ren_o`, `mem_wen_o`, `fill_wen_o` = 0; `mem_addr_o`, `mem_wdata_o`, `fill_addr_o`, `fill_line_o` = 0.
- Clean miss with zero-wait memory (ack every cycle):
  - accept at edge 0;
  - RD in cycles 1–4;
  - FILL in cycle 5;
  - `req_ready_o`=1 again in cycle 6.
- Dirty miss adds 4 WB cycles (1–4); RD then occupies 5–8 and FILL 9.
- Each memory wait cycle extends the current beat by one cycle.
- `fill_line_o`/`fill_addr_o` are meaningful only while `fill_wen_o`=1; they hold their value otherwise.

## Configuration
- `CACHE_REFILL_WRITEBACK_EN` defined: WB state and victim register are built, and dirty victims are written back before the refill.
- Not defined:
  - WB state and victim register are absent;
  - `victim_*` ports remain but are ignored;
  - `mem_wen_o` is tied 0 and `mem_wdata_o` is tied 0;
  - every accept goes straight to RD.

## Test plan
- Reset then idle: `req_ready_o`=1, all other outputs 0, `busy_o`=0.
- Clean miss `req_addr_i`=0x0000_1234, zero-wait memory returning 0x11,0x22,0x33,0x44:
  - `mem_addr_o` = 0x1230, 0x1234, 0x1238, 0x123C;
  - cycle 5: `fill_wen_o`=1, `fill_addr_o`=0x1230, `fill_line_o`=0x00000044_00000033_00000022_00000011.
- Wait states: ack withheld 2 cycles on beat 1 → `mem_addr_o` holds 0x1234 for 3 cycles; FILL lands in cycle 7 with the correct line.
- With macro, dirty victim 0x0000_ABC0, line 0xDDDD…/CCCC…/BBBB…/AAAA…:
  - 4 write beats to 0xABC0–0xABCC with words AAAA…, BBBB…, CCCC…, DDDD…;
  - then the refill;
  - `mem_ren_o` and `mem_wen_o` never both 1.
- Without macro, same stimulus: no write beats, `mem_wen_o` stays 0, FILL in cycle 5.
- `rst` asserted during RD beat 2 → next cycle IDLE, `req_ready_o`=1, no `fill_wen_o`. A new request then completes normally.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: line-refill controller between the 4-way cache and main
// memory. A miss is served as four 32-bit read beats that are assembled into
// a 128-bit line and handed to the cache as a one-cycle fill write.
// Optional feature macro: CACHE_REFILL_WRITEBACK_EN builds the WB state and
// victim register so that a dirty victim is written back before the refill.
module cache_refill_ctrl #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 4 * WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_v_i,
  input  logic [31:0]       req_addr_i,
  output logic              req_ready_o,
  input  logic              victim_dirty_i,
  input  logic [31:0]       victim_addr_i,
  input  logic [LINE_W-1:0] victim_line_i,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic [31:0]       mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              fill_wen_o,
  output logic [31:0]       fill_addr_o,
  output logic [LINE_W-1:0] fill_line_o,
  output logic              busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] FILL = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        beatCnt_q, beatCnt_d;
  logic [31:0]       lineBase_q, lineBase_d;
  logic [LINE_W-1:0] assembly_q, assembly_d;
  logic [31:0]       fillAddr_q, fillAddr_d;
  logic [LINE_W-1:0] fillLine_q, fillLine_d;

`ifdef CACHE_REFILL_WRITEBACK_EN
  logic [31:0]       victimBase_q, victimBase_d;
  logic [LINE_W-1:0] victimLine_q, victimLine_d;
  logic              unused_bits;
  assign unused_bits = ^{req_addr_i[3:0], victim_addr_i[3:0]};
`else
  logic              unused_bits;
  assign unused_bits = ^{req_addr_i[3:0], victim_dirty_i, victim_addr_i, victim_line_i};
`endif

  // Next-state logic: request accept, beat sequencing and line assembly.
  always_comb begin
    state_d    = state_q;
    beatCnt_d  = beatCnt_q;
    lineBase_d = lineBase_q;
    assembly_d = assembly_q;
    fillAddr_d = fillAddr_q;
    fillLine_d = fillLine_q;
`ifdef CACHE_REFILL_WRITEBACK_EN
    victimBase_d = victimBase_q;
    victimLine_d = victimLine_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_v_i) begin
          lineBase_d = {req_addr_i[31:4], 4'b0000};
          beatCnt_d  = 2'd0;
          state_d    = RD;
`ifdef CACHE_REFILL_WRITEBACK_EN
          if (victim_dirty_i) begin
            victimBase_d = {victim_addr_i[31:4], 4'b0000};
            victimLine_d = victim_line_i;
            state_d      = WB;
          end
`endif
        end
      end
`ifdef CACHE_REFILL_WRITEBACK_EN
      WB: begin
        if (mem_ack_i) begin
          beatCnt_d = beatCnt_q + 2'd1;
          if (beatCnt_q == 2'd3) begin
            state_d = RD;
          end
        end
      end
`endif
      RD: begin
        if (mem_ack_i) begin
          assembly_d[beatCnt_q*WORD_W +: WORD_W] = mem_rdata_i;
          beatCnt_d = beatCnt_q + 2'd1;
          if (beatCnt_q == 2'd3) begin
            fillLine_d = assembly_d;
            fillAddr_d = lineBase_q;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any partial line, victim and open beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beatCnt_q  <= 2'd0;
      lineBase_q <= '0;
      assembly_q <= '0;
      fillAddr_q <= '0;
      fillLine_q <= '0;
`ifdef CACHE_REFILL_WRITEBACK_EN
      victimBase_q <= '0;
      victimLine_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beatCnt_q  <= beatCnt_d;
      lineBase_q <= lineBase_d;
      assembly_q <= assembly_d;
      fillAddr_q <= fillAddr_d;
      fillLine_q <= fillLine_d;
`ifdef CACHE_REFILL_WRITEBACK_EN
      victimBase_q <= victimBase_d;
      victimLine_q <= victimLine_d;
`endif
    end
  end

  // Memory-side outputs decoded purely from registered state and counters.
  always_comb begin
    mem_ren_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == RD) begin
      mem_ren_o  = 1'b1;
      mem_addr_o = {lineBase_q[31:4], beatCnt_q, 2'b00};
    end
`ifdef CACHE_REFILL_WRITEBACK_EN
    if (state_q == WB) begin
      mem_wen_o   = 1'b1;
      mem_addr_o  = {victimBase_q[31:4], beatCnt_q, 2'b00};
      mem_wdata_o = victimLine_q[beatCnt_q*WORD_W +: WORD_W];
    end
`endif
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign fill_wen_o  = (state_q == FILL);
  assign fill_addr_o = fillAddr_q;
  assign fill_line_o = fillLine_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized and directed bench for cache_refill_ctrl
// with a behavioural memory and a line-level expectation model.
module tb_cache_refill_ctrl;

`ifdef CACHE_REFILL_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_v_i;
  logic [31:0]  req_addr_i;
  logic         req_ready_o;
  logic         victim_dirty_i;
  logic [31:0]  victim_addr_i;
  logic [127:0] victim_line_i;
  logic         mem_ren_o, mem_wen_o;
  logic [31:0]  mem_addr_o, mem_wdata_o;
  logic         mem_ack_i;
  logic [31:0]  mem_rdata_i;
  logic         fill_wen_o;
  logic [31:0]  fill_addr_o;
  logic [127:0] fill_line_o;
  logic         busy_o;

  int nChecks = 0;
  int nPass   = 0;

  bit           directedMem;
  int           waitCfg[8];
  logic [31:0]  rdAddrQ[$];
  logic [31:0]  wrAddrQ[$];
  logic [31:0]  wrDataQ[$];
  int           fillCount, fillCycle, addrHoldCnt;
  logic [127:0] fillLine;
  logic [31:0]  fillAddr;
  bit           bothHigh, sawWen, timedOut, readyAfter;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .req_v_i(req_v_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .victim_dirty_i(victim_dirty_i), .victim_addr_i(victim_addr_i),
    .victim_line_i(victim_line_i),
    .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .fill_wen_o(fill_wen_o), .fill_addr_o(fill_addr_o), .fill_line_o(fill_line_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Behavioural main memory contents.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (directedMem) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Reference line: the four memory words of the aligned line, word k at [32k+:32].
  function automatic logic [127:0] expLineOf(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = memWord(base + 32'(4*k));
    return l;
  endfunction

  // Drives one miss and records every observed memory beat and fill.
  task automatic runMiss(input logic [31:0] addr, input bit dirty, input logic [31:0] vAddr,
                         input logic [127:0] vLine, input int abortCycle);
    int cyc, beatIdx, waitLeft;
    bit done;
    rdAddrQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
    fillCount = 0; fillCycle = -1; addrHoldCnt = 0;
    fillLine = '0; fillAddr = '0;
    bothHigh = 0; sawWen = 0; readyAfter = 0;
    @(negedge clk);
    req_v_i = 1; req_addr_i = addr;
    victim_dirty_i = dirty; victim_addr_i = vAddr; victim_line_i = vLine;
    mem_ack_i = 1;
    @(negedge clk);
    victim_dirty_i = 0; victim_addr_i = ~vAddr; victim_line_i = ~vLine;
    cyc = 1; beatIdx = 0; waitLeft = waitCfg[0]; done = 0;
    while (!done && cyc < 100) begin
      mem_ack_i   = 0;
      mem_rdata_i = $urandom;
      req_v_i     = busy_o ? 1'($urandom % 2) : 1'b0;
      req_addr_i  = $urandom;
      if (mem_ren_o && mem_wen_o) bothHigh = 1;
      if (mem_wen_o) sawWen = 1;
      if (mem_ren_o && mem_addr_o == 32'h1234) addrHoldCnt++;
      if (abortCycle != 0 && cyc == abortCycle) begin
        rst = 1; req_v_i = 0;
        @(negedge clk);
        rst = 0;
        done = 1;
      end else if (fill_wen_o) begin
        fillCount++; fillCycle = cyc; fillLine = fill_line_o; fillAddr = fill_addr_o;
        mem_ack_i = 1'($urandom % 2);
      end else if (mem_ren_o || mem_wen_o) begin
        if (waitLeft > 0) begin
          waitLeft--;
        end else begin
          mem_ack_i = 1;
          if (mem_ren_o) begin
            rdAddrQ.push_back(mem_addr_o);
            mem_rdata_i = memWord(mem_addr_o);
          end else begin
            wrAddrQ.push_back(mem_addr_o);
            wrDataQ.push_back(mem_wdata_o);
          end
          beatIdx++;
          waitLeft = (beatIdx < 8) ? waitCfg[beatIdx] : 0;
        end
      end else if (fillCount > 0 && req_ready_o) begin
        readyAfter = (cyc == fillCycle + 1);
        done = 1;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack_i = 0; req_v_i = 0;
    timedOut = !done;
    if (timedOut) $display("[TB] FAIL timeout: no completion within 100 cycles (got busy=%0b, expected idle)", busy_o);
    if (timedOut) nChecks++;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    nChecks++; if (req_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_o); else nPass++;
    nChecks++; if ({busy_o, mem_ren_o, mem_wen_o, fill_wen_o} !== 4'b0)
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {busy_o, mem_ren_o, mem_wen_o, fill_wen_o}); else nPass++;
    nChecks++; if ({mem_addr_o, mem_wdata_o, fill_addr_o} !== 96'h0)
      $display("[TB] FAIL reset_addr_data: got %h expected 0", {mem_addr_o, mem_wdata_o, fill_addr_o}); else nPass++;
    nChecks++; if (fill_line_o !== 128'h0) $display("[TB] FAIL reset_fill_line: got %h expected 0", fill_line_o); else nPass++;
  endtask

  task automatic test_clean_miss();
    logic [31:0] expAddr[4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    directedMem = 1;
    foreach (waitCfg[i]) waitCfg[i] = 0;
    runMiss(32'h0000_1234, 1'b0, 32'h0, 128'h0, 0);
    nChecks++; if (rdAddrQ.size() !== 4) $display("[TB] FAIL clean_beats: got %0d expected 4", rdAddrQ.size()); else nPass++;
    for (int k = 0; k < 4; k++) begin
      nChecks++; if (rdAddrQ[k] !== expAddr[k]) $display("[TB] FAIL clean_addr%0d: got %h expected %h", k, rdAddrQ[k], expAddr[k]); else nPass++;
    end
    nChecks++; if (fillCycle !== 5) $display("[TB] FAIL clean_fill_cycle: got %0d expected 5", fillCycle); else nPass++;
    nChecks++; if (fillAddr !== 32'h1230) $display("[TB] FAIL clean_fill_addr: got %h expected 00001230", fillAddr); else nPass++;
    nChecks++; if (fillLine !== 128'h00000044_00000033_00000022_00000011)
      $display("[TB] FAIL clean_fill_line: got %h expected 00000044000000330000002200000011", fillLine); else nPass++;
    nChecks++; if (readyAfter !== 1'b1) $display("[TB] FAIL clean_ready_cycle6: got %b expected 1", readyAfter); else nPass++;
  endtask

  task automatic test_wait_states();
    directedMem = 1;
    foreach (waitCfg[i]) waitCfg[i] = 0;
    waitCfg[1] = 2;
    runMiss(32'h0000_1234, 1'b0, 32'h0, 128'h0, 0);
    nChecks++; if (addrHoldCnt !== 3) $display("[TB] FAIL wait_addr_hold: got %0d expected 3", addrHoldCnt); else nPass++;
    nChecks++; if (fillCycle !== 7) $display("[TB] FAIL wait_fill_cycle: got %0d expected 7", fillCycle); else nPass++;
    nChecks++; if (fillLine !== expLineOf(32'h1230)) $display("[TB] FAIL wait_fill_line: got %h expected %h", fillLine, expLineOf(32'h1230)); else nPass++;
  endtask

  task automatic test_writeback();
    logic [127:0] vLine = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    int expWrites = WB_EN ? 4 : 0;
    int expFill   = WB_EN ? 9 : 5;
    directedMem = 1;
    foreach (waitCfg[i]) waitCfg[i] = 0;
    runMiss(32'h0000_1234, 1'b1, 32'h0000_ABC0, vLine, 0);
    nChecks++; if (wrAddrQ.size() !== expWrites) $display("[TB] FAIL wb_beats: got %0d expected %0d", wrAddrQ.size(), expWrites); else nPass++;
    for (int k = 0; k < expWrites; k++) begin
      nChecks++; if (wrAddrQ[k] !== 32'hABC0 + 32'(4*k)) $display("[TB] FAIL wb_addr%0d: got %h expected %h", k, wrAddrQ[k], 32'hABC0 + 32'(4*k)); else nPass++;
      nChecks++; if (wrDataQ[k] !== vLine[32*k +: 32]) $display("[TB] FAIL wb_data%0d: got %h expected %h", k, wrDataQ[k], vLine[32*k +: 32]); else nPass++;
    end
    nChecks++; if (sawWen !== WB_EN) $display("[TB] FAIL wb_wen_seen: got %b expected %b", sawWen, WB_EN); else nPass++;
    nChecks++; if (bothHigh !== 1'b0) $display("[TB] FAIL wb_ren_wen_overlap: got %b expected 0", bothHigh); else nPass++;
    nChecks++; if (fillCycle !== expFill) $display("[TB] FAIL wb_fill_cycle: got %0d expected %0d", fillCycle, expFill); else nPass++;
    nChecks++; if (fillLine !== 128'h00000044_00000033_00000022_00000011)
      $display("[TB] FAIL wb_fill_line: got %h expected 00000044000000330000002200000011", fillLine); else nPass++;
  endtask

  task automatic test_reset_mid_burst();
    directedMem = 0;
    foreach (waitCfg[i]) waitCfg[i] = 0;
    runMiss(32'h0000_5678, 1'b0, 32'h0, 128'h0, 3);
    nChecks++; if (req_ready_o !== 1'b1) $display("[TB] FAIL abort_ready: got %b expected 1", req_ready_o); else nPass++;
    nChecks++; if ({busy_o, mem_ren_o, fill_wen_o} !== 3'b000) $display("[TB] FAIL abort_idle: got %b expected 000", {busy_o, mem_ren_o, fill_wen_o}); else nPass++;
    nChecks++; if (rdAddrQ.size() !== 2) $display("[TB] FAIL abort_beats_before: got %0d expected 2", rdAddrQ.size()); else nPass++;
    for (int c = 0; c < 4; c++) begin
      mem_ack_i = 1'($urandom % 2);
      @(negedge clk);
      nChecks++; if (fill_wen_o !== 1'b0) $display("[TB] FAIL abort_no_fill: got %b expected 0", fill_wen_o); else nPass++;
    end
    mem_ack_i = 0;
    runMiss(32'h0000_9ABC, 1'b0, 32'h0, 128'h0, 0);
    nChecks++; if (fillLine !== expLineOf(32'h9AB0)) $display("[TB] FAIL abort_recover_line: got %h expected %h", fillLine, expLineOf(32'h9AB0)); else nPass++;
    nChecks++; if (fillCycle !== 5) $display("[TB] FAIL abort_recover_cycle: got %0d expected 5", fillCycle); else nPass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [31:0]  addr  = $urandom;
      logic [31:0]  vAddr = $urandom;
      logic [127:0] vLine = {$urandom, $urandom, $urandom, $urandom};
      bit           dirty = 1'($urandom % 2);
      bit           doWb;
      int           nBeats, sumWait, expFill;
      logic [31:0]  base, vBase;
      directedMem = 0;
      foreach (waitCfg[i]) waitCfg[i] = $urandom_range(0, 3);
      doWb    = dirty && WB_EN;
      nBeats  = doWb ? 8 : 4;
      sumWait = 0;
      for (int b = 0; b < nBeats; b++) sumWait += waitCfg[b];
      expFill = 1 + nBeats + sumWait;
      base    = {addr[31:4], 4'b0};
      vBase   = {vAddr[31:4], 4'b0};
      runMiss(addr, dirty, vAddr, vLine, 0);
      nChecks++; if (fillCount !== 1) $display("[TB] FAIL rnd%0d_fill_count: got %0d expected 1", it, fillCount); else nPass++;
      nChecks++; if (fillCycle !== expFill) $display("[TB] FAIL rnd%0d_fill_cycle: got %0d expected %0d", it, fillCycle, expFill); else nPass++;
      nChecks++; if (fillAddr !== base) $display("[TB] FAIL rnd%0d_fill_addr: got %h expected %h", it, fillAddr, base); else nPass++;
      nChecks++; if (fillLine !== expLineOf(base)) $display("[TB] FAIL rnd%0d_fill_line: got %h expected %h", it, fillLine, expLineOf(base)); else nPass++;
      nChecks++; if (fill_line_o !== expLineOf(base)) $display("[TB] FAIL rnd%0d_fill_hold: got %h expected %h", it, fill_line_o, expLineOf(base)); else nPass++;
      nChecks++; if (readyAfter !== 1'b1) $display("[TB] FAIL rnd%0d_ready_after_fill: got %b expected 1", it, readyAfter); else nPass++;
      nChecks++; if (bothHigh !== 1'b0) $display("[TB] FAIL rnd%0d_ren_wen_overlap: got %b expected 0", it, bothHigh); else nPass++;
      nChecks++; if (rdAddrQ.size() !== 4) $display("[TB] FAIL rnd%0d_rd_beats: got %0d expected 4", it, rdAddrQ.size()); else nPass++;
      for (int k = 0; k < 4; k++) begin
        nChecks++; if (rdAddrQ[k] !== base + 32'(4*k)) $display("[TB] FAIL rnd%0d_rd_addr%0d: got %h expected %h", it, k, rdAddrQ[k], base + 32'(4*k)); else nPass++;
      end
      nChecks++; if (wrAddrQ.size() !== (doWb ? 4 : 0)) $display("[TB] FAIL rnd%0d_wr_beats: got %0d expected %0d", it, wrAddrQ.size(), doWb ? 4 : 0); else nPass++;
      if (doWb) begin
        for (int k = 0; k < 4; k++) begin
          nChecks++; if (wrAddrQ[k] !== vBase + 32'(4*k)) $display("[TB] FAIL rnd%0d_wr_addr%0d: got %h expected %h", it, k, wrAddrQ[k], vBase + 32'(4*k)); else nPass++;
          nChecks++; if (wrDataQ[k] !== vLine[32*k +: 32]) $display("[TB] FAIL rnd%0d_wr_data%0d: got %h expected %h", it, k, wrDataQ[k], vLine[32*k +: 32]); else nPass++;
        end
      end
    end
  endtask

  initial begin
    rst = 1; req_v_i = 0; req_addr_i = '0; victim_dirty_i = 0; victim_addr_i = '0;
    victim_line_i = '0; mem_ack_i = 0; mem_rdata_i = '0; directedMem = 0;
    foreach (waitCfg[i]) waitCfg[i] = 0;
    test_reset();
    test_clean_miss();
    test_wait_states();
    test_writeback();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
